// File: rtl/ntsc_timing_seq_if.sv
// ntsc_timing_seq_if
//   Output bundle of the NTSC line/field sequencer.
//   master: driven by ntsc_timing_seq; slave: level generator / pixel source.
//   sync, blank, burst, act : video gates (registered, aligned to h_ctr/v_ctr)
//   pix_req, x, y           : prefetched pixel request and coordinates
//   line_stb, frame_stb     : single-CK wrap strobes
//   h_ctr, v_ctr            : sample and line counters
interface ntsc_timing_seq_if;
  logic       sync;
  logic       blank;
  logic       burst;
  logic       act;
  logic       pix_req;
  logic [9:0] x;
  logic [7:0] y;
  logic       line_stb;
  logic       frame_stb;
  logic [9:0] h_ctr;
  logic [8:0] v_ctr;

  modport master (
    output sync, blank, burst, act, pix_req, x, y,
           line_stb, frame_stb, h_ctr, v_ctr
  );

  modport slave (
    input  sync, blank, burst, act, pix_req, x, y,
           line_stb, frame_stb, h_ctr, v_ctr
  );
endinterface

// File: rtl/ntsc_timing_seq.sv
// ntsc_timing_seq
//   Line/field sequencer for the NTSC composite datapath. Counts samples and
//   lines on the sample enable, decodes sync/blank/burst/active gates and issues
//   prefetched pixel coordinates ahead of the active window.
//   CK_i    : system clock (8x sample rate)
//   ARST_i  : asynchronous reset, active high
//   CK_EE_i : sample enable, one CK pulse per sample
//   RUN_i   : 1 = generate timing, 0 = hold idle at the last sample of the field
//   vid     : output bundle (gates, pixel request, strobes, counters)
module ntsc_timing_seq #(
  parameter int unsigned C_LINE_LEN  = 910,
  parameter int unsigned C_LINES     = 262,
  parameter int unsigned C_HSYNC_W   = 58,
  parameter int unsigned C_EQ_W      = 29,
  parameter int unsigned C_BURST_ST  = 65,
  parameter int unsigned C_BURST_W   = 31,
  parameter int unsigned C_H_ACT     = 134,
  parameter int unsigned C_H_ACT_LEN = 752,
  parameter int unsigned C_V_ACT     = 20,
  parameter int unsigned C_V_ACT_LEN = 240,
  parameter int unsigned C_PREFETCH  = 2
) (
  input  logic                  CK_i,
  input  logic                  ARST_i,
  input  logic                  CK_EE_i,
  input  logic                  RUN_i,
  ntsc_timing_seq_if.master     vid
);

  localparam int unsigned HW = 10;
  localparam int unsigned VW = 9;

  localparam logic [HW-1:0] H_LAST    = HW'(C_LINE_LEN - 1);
  localparam logic [HW-1:0] H_HALF    = HW'(C_LINE_LEN / 2);
  localparam logic [HW-1:0] H_EQ      = HW'(C_EQ_W);
  localparam logic [HW-1:0] H_HALF_EQ = HW'(C_LINE_LEN / 2 + C_EQ_W);
  localparam logic [HW-1:0] H_HS      = HW'(C_HSYNC_W);
  localparam logic [HW-1:0] H_SERR1   = HW'(C_LINE_LEN / 2 - C_HSYNC_W);
  localparam logic [HW-1:0] H_SERR2   = HW'(C_LINE_LEN - C_HSYNC_W);
  localparam logic [HW-1:0] H_BST     = HW'(C_BURST_ST);
  localparam logic [HW-1:0] H_BEND    = HW'(C_BURST_ST + C_BURST_W);
  localparam logic [HW-1:0] H_ACT0    = HW'(C_H_ACT);
  localparam logic [HW-1:0] H_ACT_END = HW'(C_H_ACT + C_H_ACT_LEN);
  localparam logic [HW-1:0] H_PRE0    = HW'(C_H_ACT - C_PREFETCH);
  localparam logic [HW-1:0] H_ALEN    = HW'(C_H_ACT_LEN);
  localparam logic [VW-1:0] V_LAST    = VW'(C_LINES - 1);
  localparam logic [VW-1:0] V_ACT0    = VW'(C_V_ACT);
  localparam logic [VW-1:0] V_ACT_END = VW'(C_V_ACT + C_V_ACT_LEN);
  localparam logic [VW-1:0] V_ALEN    = VW'(C_V_ACT_LEN);

  logic [HW-1:0] h_q, h_nx;
  logic [VW-1:0] v_q, v_nx;
  logic          sync_q, blank_q, burst_q, act_q, pix_q, line_q, frame_q;
  logic [9:0]    x_q;
  logic [7:0]    y_q;

  logic          sync_nx, burst_nx, act_nx, pre_nx, v_in;
  logic [HW:0]   x_diff;
  logic [VW:0]   y_diff;

  // Gates are decoded from the counter values about to be loaded, so the
  // registered gates line up with the registered counters.
  always_comb begin
    h_nx = (h_q == H_LAST) ? '0 : h_q + HW'(1);
    v_nx = v_q;
    if (h_q == H_LAST)
      v_nx = (v_q == V_LAST) ? '0 : v_q + VW'(1);

    if (v_nx < VW'(3) || (v_nx >= VW'(6) && v_nx < VW'(9)))
      sync_nx = (h_nx < H_EQ) || (h_nx >= H_HALF && h_nx < H_HALF_EQ);
    else if (v_nx < VW'(6))
      sync_nx = !((h_nx >= H_SERR1 && h_nx < H_HALF) || h_nx >= H_SERR2);
    else
      sync_nx = h_nx < H_HS;

    burst_nx = (v_nx >= VW'(9)) && (h_nx >= H_BST) && (h_nx < H_BEND);
    v_in     = (v_nx >= V_ACT0) && (v_nx < V_ACT_END);
    act_nx   = v_in && (h_nx >= H_ACT0) && (h_nx < H_ACT_END);

    // One extra bit on the offsets: a set MSB means "before the window",
    // which doubles as the lower window bound.
    x_diff = {1'b0, h_nx} - {1'b0, H_PRE0};
    y_diff = {1'b0, v_nx} - {1'b0, V_ACT0};
    pre_nx = !x_diff[HW] && (x_diff[HW-1:0] < H_ALEN) &&
             !y_diff[VW] && (y_diff[VW-1:0] < V_ALEN);
  end

  always_ff @(posedge CK_i or posedge ARST_i) begin
    if (ARST_i) begin
      h_q     <= H_LAST;
      v_q     <= V_LAST;
      sync_q  <= 1'b0;
      blank_q <= 1'b1;
      burst_q <= 1'b0;
      act_q   <= 1'b0;
      pix_q   <= 1'b0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
    end else if (!RUN_i) begin
      // Park on the last sample so the first enabled sample wraps to (0,0).
      h_q     <= H_LAST;
      v_q     <= V_LAST;
      sync_q  <= 1'b0;
      blank_q <= 1'b1;
      burst_q <= 1'b0;
      act_q   <= 1'b0;
      pix_q   <= 1'b0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
    end else if (CK_EE_i) begin
      h_q     <= h_nx;
      v_q     <= v_nx;
      sync_q  <= sync_nx;
      blank_q <= !act_nx && !sync_nx;
      burst_q <= burst_nx;
      act_q   <= act_nx;
      pix_q   <= pre_nx;
      line_q  <= (h_nx == '0);
      frame_q <= (h_nx == '0) && (v_nx == '0);
      if (pre_nx) begin
        x_q <= x_diff[9:0];
        y_q <= y_diff[7:0];
      end
    end else begin
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end
  end

  assign vid.h_ctr     = h_q;
  assign vid.v_ctr     = v_q;
  assign vid.sync      = sync_q;
  assign vid.blank     = blank_q;
  assign vid.burst     = burst_q;
  assign vid.act       = act_q;
  assign vid.pix_req   = pix_q;
  assign vid.line_stb  = line_q;
  assign vid.frame_stb = frame_q;
  assign vid.x         = x_q;
  assign vid.y         = y_q;

  // Window constants must keep the prefetch and active window inside the line.
  a_legal_window: assert property (@(posedge CK_i)
    (C_H_ACT >= C_PREFETCH) && (C_H_ACT + C_H_ACT_LEN <= C_LINE_LEN));

endmodule

// File: tb/tb_ntsc_timing_seq.sv
module tb_ntsc_timing_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic run = 1'b0;
  logic ee  = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int ee_mode = 0;      // 0 off, 1 every CK, 8 every 8 CK, 2 random
  int ee_cnt  = 0;
  bit cmp_en  = 0;
  bit mon_line = 0, mon_frame = 0, mon_hold = 0;
  int n_lp = 0, n_fp = 0, n_hold = 0;

  initial forever #5 clk = ~clk;

  ntsc_timing_seq_if vid_a ();
  ntsc_timing_seq_if vid_b ();

  ntsc_timing_seq dut_a (
    .CK_i(clk), .ARST_i(rst), .CK_EE_i(ee), .RUN_i(run), .vid(vid_a)
  );

  ntsc_timing_seq #(
    .C_LINE_LEN(100), .C_LINES(30), .C_HSYNC_W(6), .C_EQ_W(3),
    .C_BURST_ST(8), .C_BURST_W(4), .C_H_ACT(20), .C_H_ACT_LEN(70),
    .C_V_ACT(12), .C_V_ACT_LEN(15), .C_PREFETCH(2)
  ) dut_b (
    .CK_i(clk), .ARST_i(rst), .CK_EE_i(ee), .RUN_i(run), .vid(vid_b)
  );

  // Per-instance frame geometry for the reference model.
  int P_L[2]   = '{910, 100};
  int P_N[2]   = '{262, 30};
  int P_HS[2]  = '{58, 6};
  int P_EQ[2]  = '{29, 3};
  int P_BS[2]  = '{65, 8};
  int P_BW[2]  = '{31, 4};
  int P_HA[2]  = '{134, 20};
  int P_HAL[2] = '{752, 70};
  int P_VA[2]  = '{20, 12};
  int P_VAL[2] = '{240, 15};
  int P_PF[2]  = '{2, 2};

  typedef struct packed {
    logic       sync, blank, burst, act, pix, lstb, fstb;
    logic [9:0] x;
    logic [7:0] y;
    logic [9:0] h;
    logic [8:0] v;
  } obs_t;

  obs_t obs_a, obs_b;
  obs_t mdl [2];

  assign obs_a = {vid_a.sync, vid_a.blank, vid_a.burst, vid_a.act, vid_a.pix_req,
                  vid_a.line_stb, vid_a.frame_stb, vid_a.x, vid_a.y,
                  vid_a.h_ctr, vid_a.v_ctr};
  assign obs_b = {vid_b.sync, vid_b.blank, vid_b.burst, vid_b.act, vid_b.pix_req,
                  vid_b.line_stb, vid_b.frame_stb, vid_b.x, vid_b.y,
                  vid_b.h_ctr, vid_b.v_ctr};

  function automatic obs_t get_obs(int i);
    return (i == 0) ? obs_a : obs_b;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("sync=%0b blank=%0b burst=%0b act=%0b pix=%0b lstb=%0b fstb=%0b x=%0d y=%0d h=%0d v=%0d",
                     o.sync, o.blank, o.burst, o.act, o.pix, o.lstb, o.fstb, o.x, o.y, o.h, o.v);
  endfunction

  task automatic chk(input string nm, input int got, input int exp_v);
    checks++;
    if (got != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp_v, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit sync_rule(int i, int h, int v);
    int half = P_L[i] / 2;
    if (v <= 2 || (v >= 6 && v <= 8))
      return (h < P_EQ[i]) || (h >= half && h < half + P_EQ[i]);
    if (v <= 5)
      return !((h >= half - P_HS[i] && h < half) || h >= P_L[i] - P_HS[i]);
    return h < P_HS[i];
  endfunction

  function automatic obs_t idle(int i);
    obs_t n = '0;
    n.h = 10'(P_L[i] - 1);
    n.v = 9'(P_N[i] - 1);
    n.blank = 1'b1;
    return n;
  endfunction

  function automatic obs_t next_obs(int i, obs_t c, logic run_v, logic ee_v);
    obs_t n = c;
    int idx, h, v, pre_h;
    bit v_act, pre;
    if (!run_v) return idle(i);
    if (!ee_v) begin
      n.lstb = 1'b0;
      n.fstb = 1'b0;
      return n;
    end
    // Linear sample index within the field, advanced by one and folded.
    idx = (int'(c.v) * P_L[i] + int'(c.h) + 1) % (P_L[i] * P_N[i]);
    h = idx % P_L[i];
    v = idx / P_L[i];
    v_act = (v >= P_VA[i]) && (v < P_VA[i] + P_VAL[i]);
    pre_h = P_HA[i] - P_PF[i];
    pre = v_act && (h >= pre_h) && (h < pre_h + P_HAL[i]);
    n.h = 10'(h);
    n.v = 9'(v);
    n.lstb = (h == 0);
    n.fstb = (idx == 0);
    n.sync = sync_rule(i, h, v);
    n.burst = (v >= 9) && (h >= P_BS[i]) && (h < P_BS[i] + P_BW[i]);
    n.act = v_act && (h >= P_HA[i]) && (h < P_HA[i] + P_HAL[i]);
    n.blank = !n.act && !n.sync;
    n.pix = pre;
    if (pre) begin
      n.x = 10'(h - pre_h);
      n.y = 8'(v - P_VA[i]);
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mdl[0] <= idle(0);
      mdl[1] <= idle(1);
    end else begin
      mdl[0] <= next_obs(0, mdl[0], run, ee);
      mdl[1] <= next_obs(1, mdl[1], run, ee);
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (get_obs(i) !== mdl[i]) begin
          errors++;
          $display("FAIL model dut%0d t=%0t: got %s ; expected %s",
                   i, $time, fmt(get_obs(i)), fmt(mdl[i]));
        end
      end
    end
  end

  // ---------------- hand-computed anchor points ----------------
  typedef struct {
    int d, v, h, sync, burst, act, pix, x, y;
  } pt_t;

  pt_t pts [] = '{
    '{0, 10,  57, 1, 0, 0, 0,  -1, -1},
    '{0, 10,  58, 0, 0, 0, 0,  -1, -1},
    '{0, 10,  64, 0, 0, 0, 0,  -1, -1},
    '{0, 10,  65, 0, 1, 0, 0,  -1, -1},
    '{0, 10,  95, 0, 1, 0, 0,  -1, -1},
    '{0, 10,  96, 0, 0, 0, 0,  -1, -1},
    '{0,  4, 396, 1, 0, 0, 0,  -1, -1},
    '{0,  4, 397, 0, 0, 0, 0,  -1, -1},
    '{0,  4, 454, 0, 0, 0, 0,  -1, -1},
    '{0,  4, 455, 1, 0, 0, 0,  -1, -1},
    '{0,  4, 851, 1, 0, 0, 0,  -1, -1},
    '{0,  4, 852, 0, 0, 0, 0,  -1, -1},
    '{0,  4, 909, 0, 0, 0, 0,  -1, -1},
    '{0,  1,  28, 1, 0, 0, 0,  -1, -1},
    '{0,  1,  29, 0, 0, 0, 0,  -1, -1},
    '{0,  1, 454, 0, 0, 0, 0,  -1, -1},
    '{0,  1, 455, 1, 0, 0, 0,  -1, -1},
    '{0,  1, 483, 1, 0, 0, 0,  -1, -1},
    '{0,  1, 484, 0, 0, 0, 0,  -1, -1},
    '{0, 20, 131, 0, 0, 0, 0,  -1, -1},
    '{0, 20, 132, 0, 0, 0, 1,   0,  0},
    '{0, 20, 133, 0, 0, 0, 1,   1,  0},
    '{0, 20, 134, 0, 0, 1, 1,   2,  0},
    '{0, 20, 883, 0, 0, 1, 1, 751,  0},
    '{0, 20, 884, 0, 0, 1, 0, 751,  0},
    '{0, 20, 885, 0, 0, 1, 0, 751,  0},
    '{0, 20, 886, 0, 0, 0, 0, 751,  0},
    '{0, 21, 132, 0, 0, 0, 1,   0,  1},
    '{1, 12,  18, 0, 0, 0, 1,   0,  0},
    '{1, 12,  20, 0, 0, 1, 1,   2,  0},
    '{1, 26,  18, 0, 0, 0, 1,   0, 14},
    '{1, 26,  87, 0, 0, 1, 1,  69, 14},
    '{1, 26,  89, 0, 0, 1, 0,  69, 14},
    '{1, 27,  20, 0, 0, 0, 0,  69, 14},
    '{1,  4,  43, 1, 0, 0, 0,  -1, -1},
    '{1,  4,  44, 0, 0, 0, 0,  -1, -1},
    '{1, 10,   5, 1, 0, 0, 0,  -1, -1},
    '{1, 10,   8, 0, 1, 0, 0,  -1, -1}
  };
  bit pt_done [];

  // ---------------- monitors: anchors, strobe width/period, hold ----------------
  initial begin
    int last_l, last_f;
    bit prev [4];
    bit cur [4];
    obs_t o;
    last_l = -1;
    last_f = -1;
    prev = '{0, 0, 0, 0};
    pt_done = new[pts.size()];
    forever begin
      @(negedge clk);
      cyc++;
      if (cmp_en && !rst) begin
        for (int k = 0; k < pts.size(); k++) begin
          o = get_obs(pts[k].d);
          if (!pt_done[k] && run && int'(o.h) == pts[k].h && int'(o.v) == pts[k].v) begin
            pt_done[k] = 1;
            chk($sformatf("pt%0d_sync", k), int'(o.sync), pts[k].sync);
            chk($sformatf("pt%0d_burst", k), int'(o.burst), pts[k].burst);
            chk($sformatf("pt%0d_act", k), int'(o.act), pts[k].act);
            chk($sformatf("pt%0d_pix", k), int'(o.pix), pts[k].pix);
            chk($sformatf("pt%0d_blank", k), int'(o.blank),
                int'(pts[k].act == 0 && pts[k].sync == 0));
            if (pts[k].x >= 0) chk($sformatf("pt%0d_x", k), int'(o.x), pts[k].x);
            if (pts[k].y >= 0) chk($sformatf("pt%0d_y", k), int'(o.y), pts[k].y);
          end
        end
      end
      cur = '{vid_a.line_stb, vid_a.frame_stb, vid_b.line_stb, vid_b.frame_stb};
      for (int s = 0; s < 4; s++) begin
        if (cur[s]) chk($sformatf("stb%0d_width", s), int'(prev[s]), 0);
        prev[s] = cur[s];
      end
      if (mon_hold && (cur[0] || cur[1] || cur[2] || cur[3])) n_hold++;
      if (!mon_line) last_l = -1;
      else if (vid_a.line_stb) begin
        if (last_l >= 0) begin chk("line_period", cyc - last_l, 7280); n_lp++; end
        last_l = cyc;
      end
      if (!mon_frame) last_f = -1;
      else if (vid_b.frame_stb) begin
        if (last_f >= 0) begin chk("frame_period_b", cyc - last_f, 100 * 30); n_fp++; end
        last_f = cyc;
      end
    end
  end

  // ---------------- sample enable generator ----------------
  initial forever begin
    @(negedge clk);
    ee_cnt++;
    case (ee_mode)
      1:       ee = 1'b1;
      8:       ee = (ee_cnt % 8 == 0);
      2:       ee = ($urandom_range(0, 3) == 0);
      default: ee = 1'b0;
    endcase
  end

  task automatic wait_ee(input string nm);
    bit ok = 0;
    for (int k = 0; k < 64 && !ok; k++) begin
      @(posedge clk);
      if (ee) ok = 1;
    end
    #1;
    if (!ok) chk({nm, "_ee_timeout"}, 0, 1);
  endtask

  task automatic chk_origin(input string nm);
    chk({nm, "_h"}, int'(vid_a.h_ctr), 0);
    chk({nm, "_v"}, int'(vid_a.v_ctr), 0);
    chk({nm, "_lstb"}, int'(vid_a.line_stb), 1);
    chk({nm, "_fstb"}, int'(vid_a.frame_stb), 1);
    chk({nm, "_sync"}, int'(vid_a.sync), 1);
    chk({nm, "_b_fstb"}, int'(vid_b.frame_stb), 1);
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_h"}, int'(vid_a.h_ctr), 909);
    chk({nm, "_v"}, int'(vid_a.v_ctr), 261);
    chk({nm, "_blank"}, int'(vid_a.blank), 1);
    chk({nm, "_sync"}, int'(vid_a.sync), 0);
    chk({nm, "_act"}, int'(vid_a.act), 0);
    chk({nm, "_pix"}, int'(vid_a.pix_req), 0);
    chk({nm, "_x"}, int'(vid_a.x), 0);
    chk({nm, "_stb"}, int'(vid_a.line_stb | vid_a.frame_stb), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit found;
    int n;
    #1 rst = 1'b1;
    cmp_en = 1;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    chk("reset_burst", int'(vid_a.burst), 0);
    chk("reset_y", int'(vid_a.y), 0);

    rst = 1'b0;
    ee_mode = 8;
    run = 1'b1;
    wait_ee("start");
    chk_origin("start");

    repeat ($urandom_range(100, 300)) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_idle("arst");
    @(negedge clk) rst = 1'b0;
    wait_ee("arst_restart");
    chk_origin("arst_restart");

    @(negedge clk);
    mon_line = 1;
    repeat (16000) @(negedge clk);
    mon_line = 0;

    ee_mode = 1;
    @(negedge clk);
    mon_frame = 1;
    found = 0;
    for (int k = 0; k < 60000 && !found; k++) begin
      @(negedge clk);
      if (vid_a.h_ctr == 10'd300 && vid_a.v_ctr == 9'd50) found = 1;
    end
    mon_frame = 0;
    chk("reach_300_50", int'(found), 1);

    run = 1'b0;
    ee_mode = 8;
    @(posedge clk);
    #1 chk_idle("run_drop");
    n = 0;
    for (int k = 0; k < 200 && n < 5; k++) begin
      @(posedge clk);
      if (ee) n++;
    end
    chk("idle_ee_count", n, 5);
    @(negedge clk) run = 1'b1;
    wait_ee("rerun");
    chk_origin("rerun");

    @(negedge clk) ee_mode = 0;
    repeat (2) @(negedge clk);
    n_hold = 0;
    mon_hold = 1;
    repeat (100) @(negedge clk);
    mon_hold = 0;
    chk("hold_strobes", n_hold, 0);

    ee_mode = 2;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      if (k == 2000) begin
        #2 rst = 1'b1;
        #2 rst = 1'b0;
      end else if ($urandom_range(0, 199) == 0) run = 1'b0;
      else if (!run && $urandom_range(0, 7) == 0) run = 1'b1;
    end
    run = 1'b1;
    repeat (4) @(negedge clk);

    for (int k = 0; k < pts.size(); k++)
      chk($sformatf("pt%0d_reached", k), int'(pt_done[k]), 1);
    chk("line_periods_seen", int'(n_lp >= 1), 1);
    chk("frame_periods_seen", int'(n_fp >= 3), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
